demux17_router: RTL and testbench

Registered 1-to-2 steering stage for 17-bit (N+1-bit) fixed-point words in the ELM datapath; it is the inverse of the 2:1 17-bit select used on the multiplier operand path. It accepts one word per cycle on a valid/ready input and routes it to one of two output channels, each holding a one-entry output register. The destination comes either from a per-word select sideband or from an internal ping-pong pointer (even/odd split). Per-channel delivered-word counters support hidden-layer bookkeeping and verification.

---
 rtl/elm_pkg.sv | 21 ++
 rtl/demux17_router_if.sv | 38 +++
 rtl/demux_slot.sv | 54 +++++
 rtl/demux17_router.sv | 74 +++++++
 tb/tb_demux17_router.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/elm_pkg.sv
// Shared definitions for the ELM datapath steering blocks.
//   DATA_N      : MSB index of a datapath word (words are DATA_N+1 bits)
//   word17_t    : one fixed-point datapath word
//   CH0 / CH1   : output channel indices
//   slot_state_t: occupancy of a one-entry output register
package elm_pkg;

    localparam int DATA_N    = 16;
    localparam int CNT_W_DEF = 8;

    typedef logic [DATA_N:0] word17_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux17_router_if.sv
// Bus bundle for demux17_router: one valid/ready input stream with a
// select sideband and mode control, two valid/ready output channels and
// the pointer/counter observation outputs.
//   master : upstream/downstream side (drives input word and out readies)
//   slave  : router side
interface demux17_router_if
    import elm_pkg::*;
#(
    parameter int N     = DATA_N,
    parameter int CNT_W = CNT_W_DEF
);
    logic [N:0]       in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [N:0]       out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [N:0]       out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic             pp_ptr;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output in_data, in_sel, in_valid, mode, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
               pp_ptr, cnt0, cnt1
    );

    modport slave (
        input  in_data, in_sel, in_valid, mode, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid,
               pp_ptr, cnt0, cnt1
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry output register for one router channel.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : take load_data this cycle (becomes/stays FULL)
//   load_data : word to store
//   out_ready : downstream takes the word when FULL
//   out_data  : stored word (holds its last value while EMPTY)
//   out_valid : register FULL
//   cnt       : number of words drained, modulo 2^CNT_W
module demux_slot
    import elm_pkg::*;
#(
    parameter int N     = DATA_N,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N:0]       load_data,
    input  logic             out_ready,
    output logic [N:0]       out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt
);
    slot_state_t      state_reg;
    logic [N:0]       data_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             drain;

    assign drain = (state_reg == SLOT_FULL) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SLOT_EMPTY;
            data_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            // A load wins over a drain so a simultaneous drain+load keeps
            // the slot FULL with the new word and no bubble.
            if (load) begin
                data_reg  <= load_data;
                state_reg <= SLOT_FULL;
            end else if (drain) begin
                state_reg <= SLOT_EMPTY;
            end
            if (drain) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_data  = data_reg;
    assign out_valid = (state_reg == SLOT_FULL);
    assign cnt       = cnt_reg;
endmodule

// File: rtl/demux17_router.sv
// Registered 1-to-2 steering stage for N+1-bit words. Each accepted word
// goes to channel in_sel (mode=0) or to the ping-pong pointer channel
// (mode=1); each channel is a one-entry register with a drain counter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : demux17_router_if slave modport (input stream, two output
//              channels, pp_ptr, cnt0/cnt1)
module demux17_router
    import elm_pkg::*;
#(
    parameter int N     = DATA_N,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    demux17_router_if.slave bus
);
    logic             target;
    logic             in_ready_int;
    logic             accept;
    logic             pp_ptr_reg;
    logic [1:0]       full;
    logic [1:0]       out_ready_vec;
    logic [1:0]       load;
    logic [N:0]       data_vec [2];
    logic [CNT_W-1:0] cnt_vec  [2];

    assign out_ready_vec = {bus.out1_ready, bus.out0_ready};

    assign target = bus.mode ? pp_ptr_reg : bus.in_sel;

    // Combinational out_ready -> in_ready lets a FULL target drain and
    // refill in the same cycle; it never depends on in_valid.
    assign in_ready_int = ~full[target] | out_ready_vec[target];
    assign accept       = bus.in_valid & in_ready_int;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign load[gi] = accept & (target == 1'(gi));

            demux_slot #(
                .N     (N),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (load[gi]),
                .load_data (bus.in_data),
                .out_ready (out_ready_vec[gi]),
                .out_data  (data_vec[gi]),
                .out_valid (full[gi]),
                .cnt       (cnt_vec[gi])
            );
        end
    endgenerate

    // Pointer advances only on accepted words in ping-pong mode; it holds
    // through mode=0 periods and resumes from there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_ptr_reg <= CH0;
        end else if (accept && bus.mode) begin
            pp_ptr_reg <= ~pp_ptr_reg;
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out0_data  = data_vec[CH0];
    assign bus.out0_valid = full[CH0];
    assign bus.out1_data  = data_vec[CH1];
    assign bus.out1_valid = full[CH1];
    assign bus.pp_ptr     = pp_ptr_reg;
    assign bus.cnt0       = cnt_vec[CH0];
    assign bus.cnt1       = cnt_vec[CH1];
endmodule

// File: tb/tb_demux17_router.sv
module tb_demux17_router;
    import elm_pkg::*;

    logic clk;
    logic rst;

    demux17_router_if #(.N(16), .CNT_W(8)) bus();

    demux17_router #(.N(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is a queue of words not yet taken downstream.
    word17_t    mq0[$];
    word17_t    mq1[$];
    logic       m_ptr;
    logic [7:0] m_cnt0;
    logic [7:0] m_cnt1;
    word17_t    drained0[$];

    function automatic logic m_in_ready();
        logic tg;
        tg = bus.mode ? m_ptr : bus.in_sel;
        if (tg) return (mq1.size() == 0) || bus.out1_ready;
        else    return (mq0.size() == 0) || bus.out0_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic tg;
        logic acc;
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_ptr  = 1'b0;
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            tg  = bus.mode ? m_ptr : bus.in_sel;
            acc = bus.in_valid && m_in_ready();
            if (mq0.size() != 0 && bus.out0_ready) begin
                void'(mq0.pop_front());
                m_cnt0 = m_cnt0 + 8'd1;
            end
            if (mq1.size() != 0 && bus.out1_ready) begin
                void'(mq1.pop_front());
                m_cnt1 = m_cnt1 + 8'd1;
            end
            if (acc) begin
                if (tg) mq1.push_back(bus.in_data);
                else    mq0.push_back(bus.in_data);
                if (bus.mode) m_ptr = ~m_ptr;
                $display("accept ch%0d data %05h mode %0d", tg, bus.in_data, bus.mode);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
            check("out0_valid", 32'(bus.out0_valid), 32'(mq0.size() != 0));
            check("out1_valid", 32'(bus.out1_valid), 32'(mq1.size() != 0));
            if (mq0.size() != 0) check("out0_data", 32'(bus.out0_data), 32'(mq0[0]));
            if (mq1.size() != 0) check("out1_data", 32'(bus.out1_data), 32'(mq1[0]));
            check("pp_ptr", 32'(bus.pp_ptr), 32'(m_ptr));
            check("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
            check("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
            if (bus.out0_valid && bus.out0_ready) drained0.push_back(bus.out0_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic s, input word17_t d,
                        input logic m, input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.mode       = m;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
        check({tag, "_out0_valid"}, 32'(bus.out0_valid), 32'd0);
        check({tag, "_out1_valid"}, 32'(bus.out1_valid), 32'd0);
        check({tag, "_out0_data"},  32'(bus.out0_data),  32'd0);
        check({tag, "_out1_data"},  32'(bus.out1_data),  32'd0);
        check({tag, "_pp_ptr"},     32'(bus.pp_ptr),     32'd0);
        check({tag, "_cnt0"},       32'(bus.cnt0),       32'd0);
        check({tag, "_cnt1"},       32'(bus.cnt1),       32'd0);
    endtask

    word17_t w4 [10];

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.mode       = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        // Select mode, one word per channel
        step(1, 0, 17'h10001, 0, 1, 1);
        check("t1_out0_valid", 32'(bus.out0_valid), 32'd1);
        check("t1_out0_data",  32'(bus.out0_data),  32'h10001);
        step(1, 1, 17'h0FFFF, 0, 1, 1);
        check("t1_out1_valid", 32'(bus.out1_valid), 32'd1);
        check("t1_out1_data",  32'(bus.out1_data),  32'h0FFFF);
        check("t1_out0_drained", 32'(bus.out0_valid), 32'd0);
        step(0, 0, 17'h0, 0, 1, 1);
        check("t1_cnt0", 32'(bus.cnt0), 32'd1);
        check("t1_cnt1", 32'(bus.cnt1), 32'd1);

        // Ping-pong stream of 8 words
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 17'(i), 1, 1, 1);
            if (i % 2 == 0) check("t2_even_to_ch0", 32'(bus.out0_data), 32'(i));
            else            check("t2_odd_to_ch1",  32'(bus.out1_data), 32'(i));
        end
        step(0, 0, 17'h0, 1, 1, 1);
        check("t2_pp_ptr", 32'(bus.pp_ptr), 32'd0);
        check("t2_cnt0",   32'(bus.cnt0),   32'd5);
        check("t2_cnt1",   32'(bus.cnt1),   32'd5);

        // Back-pressure on ch0
        step(1, 0, 17'h1AAAA, 0, 0, 1);
        check("t3_first_held", 32'(bus.out0_data), 32'h1AAAA);
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 17'h05555, 0, 0, 1);
            check("t3_stall_ready", 32'(bus.in_ready),   32'd0);
            check("t3_stall_valid", 32'(bus.out0_valid), 32'd1);
            check("t3_stall_data",  32'(bus.out0_data),  32'h1AAAA);
        end
        bus.out0_ready = 1'b1;
        #1;
        check("t3_ready_comb", 32'(bus.in_ready), 32'd1);
        step(1, 0, 17'h05555, 0, 1, 1);
        check("t3_second_valid", 32'(bus.out0_valid), 32'd1);
        check("t3_second_data",  32'(bus.out0_data),  32'h05555);
        step(0, 0, 17'h0, 0, 1, 1);
        check("t3_empty", 32'(bus.out0_valid), 32'd0);
        check("t3_cnt0",  32'(bus.cnt0),       32'd7);

        // Drain + accept on ch0 every cycle
        drained0.delete();
        for (int i = 0; i < 10; i++) begin
            w4[i] = 17'(i * 17'h1357 + 17'h100);
            step(1, 0, w4[i], 0, 1, 1);
            check("t4_valid_cont", 32'(bus.out0_valid), 32'd1);
        end
        step(0, 0, 17'h0, 0, 1, 1);
        check("t4_drain_count", 32'(drained0.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < drained0.size()) check("t4_order", 32'(drained0[i]), 32'(w4[i]));
        end
        check("t4_cnt0", 32'(bus.cnt0), 32'd17);

        // Counter wrap on ch1 from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 257; i++) step(1, 1, 17'(i), 0, 1, 1);
        step(0, 1, 17'h0, 0, 1, 1);
        check("t5_cnt1_wrap", 32'(bus.cnt1), 32'd1);
        check("t5_cnt0",      32'(bus.cnt0), 32'd0);

        // Asynchronous reset with both channels FULL and pp_ptr=1
        step(1, 0, 17'h1BEEF, 1, 0, 0);
        step(1, 1, 17'h0CAFE, 0, 0, 0);
        bus.in_valid = 1'b0;
        check("t6_full0",  32'(bus.out0_valid), 32'd1);
        check("t6_full1",  32'(bus.out1_valid), 32'd1);
        check("t6_ptr",    32'(bus.pp_ptr),     32'd1);
        check("t6_data1",  32'(bus.out1_data),  32'h0CAFE);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 17'h0, 0, 1, 1);
        check("t6_after_valid0", 32'(bus.out0_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
